mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; storage holds 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, wait cycles per access; legal range 1..7.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request, held by requester until i_ack.
REQ-006 i_addr  input  32  instruction byte address.
REQ-007 i_rdata  output  32  fetched instruction word.
REQ-008 i_ack  output  1  one-cycle completion pulse for the instruction port.
REQ-009 d_req  input  1  data request, held by requester until d_ack.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_rdata  output  32  read data.
REQ-014 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-015 busy  output  1  high while a transaction is in progress.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; one transaction in flight at a time.
REQ-017 IDLE: at an edge with any req high, grant one port and latch port ID, word index, we and wdata; load the wait counter with LATENCY; go to WAIT.
REQ-018 Arbitration: the data port wins by default; if both requests are high and the previous grant was data, the instruction port wins (round-robin); the previous-grant flag resets to "instruction".
REQ-019 Word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored (aliasing, no error).
REQ-020 WAIT: the counter decrements each edge; at the edge where it reaches 0, go to RESP.
REQ-021 That same edge performs the write, or registers the storage word into the granted port's rdata and holds the other port's rdata.
REQ-022 RESP lasts exactly one cycle: the granted port's ack is high, busy is high, and all req inputs are ignored; the next edge returns to IDLE.
REQ-023 Ack therefore rises LATENCY+1 cycles after the accepting edge; the minimum request-to-request spacing is LATENCY+2 cycles.
REQ-024 Write completion: d_ack is pulsed and d_rdata is unchanged.
REQ-025 Read-after-write returns the newly written value.
REQ-026 i_rdata and d_rdata each hold their last value until that port's next read completes.
REQ-027 A req deasserted before its ack does not cancel the transaction; it completes and is acked normally.
REQ-028 A req arriving while busy is not queued; it is sampled only in IDLE.
REQ-029 i_ack and d_ack are never high in the same cycle.
REQ-030 The instruction port is read-only; it never writes storage.

Reset
REQ-031 On reset assertion, independent of clk: state = IDLE, counter = 0, previous grant = instruction, i_ack = d_ack = busy = 0, i_rdata = d_rdata = 0.
REQ-032 Reset during WAIT or RESP aborts the transaction: no ack, and no storage write unless the write edge has already occurred.
REQ-033 Storage contents are not cleared by reset.
REQ-034 The first request is accepted at the first rising edge after reset deasserts.

Verification
REQ-035 LATENCY=2; d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF accepted at edge E0 -> d_ack high only in the cycle after E0+2, busy high from E0 to E0+3.
REQ-036 Then i_req, i_addr=0x40 -> i_rdata=0xDEADBEEF with i_ack; d_rdata unchanged.
REQ-037 i_req and d_req both high from IDLE after reset, d read 0x40 -> data acked first, then instruction; d_ack and i_ack never overlap; total 2*(LATENCY+2) cycles.
REQ-038 Requests held continuously on both ports -> grants alternate D, I, D, I.
REQ-039 Write 0x11111111 to 0x44, then read 0x47 and read 0x1044 (ADDR_W=10) -> both return 0x11111111.
REQ-040 Write 0x22222222 to 0x44, assert reset one cycle after acceptance, then read 0x44 -> no d_ack during the aborted access, outputs 0 during reset, read returns 0x11111111.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory shared by an instruction port and a data port.
// One access in flight at a time, with a fixed wait of LATENCY cycles (1..7)
// followed by a one-cycle response in which the granted port's ack is high.
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                last_data_q, last_data_d;  // previous grant went to the data port
  logic                gnt_data_q,  gnt_data_d;   // current transaction belongs to the data port
  logic                we_q,        we_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                i_ack_q,     i_ack_d;
  logic                d_ack_q,     d_ack_d;
  logic                busy_q,      busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word_c;
  logic                mem_we_c;
  logic                sel_data_c;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_c;
  assign unused_addr_c = ^{i_addr, d_addr};

  assign rd_word_c = mem[idx_q];

  // Next-state, arbitration and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    busy_d      = busy_q;
    mem_we_c    = 1'b0;
    sel_data_c  = d_req && !(i_req && last_data_q);

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          gnt_data_d  = sel_data_c;
          last_data_d = sel_data_c;
          idx_d       = sel_data_c ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
          we_d        = sel_data_c && d_we;
          wdata_d     = d_wdata;
          cnt_d       = CNT_W'(LATENCY);
          busy_d      = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          if (we_q) begin
            mem_we_c = 1'b1;
          end else if (gnt_data_q) begin
            d_rdata_d = rd_word_c;
          end else begin
            i_rdata_d = rd_word_c;
          end
          if (gnt_data_q) begin
            d_ack_d = 1'b1;
          end else begin
            i_ack_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        i_req   = 1'b0;
  logic [31:0] i_addr  = 32'h0;
  logic        d_req   = 1'b0;
  logic        d_we    = 1'b0;
  logic [31:0] d_addr  = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] i_rdata;
  logic [31:0] d_rdata;
  logic        i_ack;
  logic        d_ack;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: counts edges since acceptance of the current access.
  bit          m_busy = 1'b0, m_gnt_data = 1'b0, m_we = 1'b0, m_last_data = 1'b0;
  bit          m_iack = 1'b0, m_dack = 1'b0;
  int unsigned m_t = 0, m_idx = 0;
  logic [31:0] m_wdata = 32'h0, m_irdata = 32'h0, m_drdata = 32'h0;
  logic [31:0] m_mem [int unsigned];

  function automatic logic [31:0] mem_rd(input int unsigned idx);
    if (m_mem.exists(idx)) return m_mem[idx];
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_t = 0; m_last_data = 1'b0;
      m_iack = 1'b0; m_dack = 1'b0; m_irdata = 32'h0; m_drdata = 32'h0;
    end else begin
      m_iack = 1'b0;
      m_dack = 1'b0;
      if (!m_busy) begin
        if (i_req || d_req) begin
          m_gnt_data  = d_req && !(i_req && m_last_data);
          m_last_data = m_gnt_data;
          m_idx       = ((m_gnt_data ? d_addr : i_addr) >> 2) % DEPTH;
          m_we        = m_gnt_data && d_we;
          m_wdata     = d_wdata;
          m_busy      = 1'b1;
          m_t         = 0;
        end
      end else begin
        m_t++;
        if (m_t == LAT) begin
          if (m_we) m_mem[m_idx] = m_wdata;
          else if (m_gnt_data) m_drdata = mem_rd(m_idx);
          else m_irdata = mem_rd(m_idx);
          if (m_gnt_data) m_dack = 1'b1;
          else m_iack = 1'b1;
        end else if (m_t == LAT + 1) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled after the falling edge.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_busy",    32'(busy),    32'(m_busy));
      check("cyc_i_ack",   32'(i_ack),   32'(m_iack));
      check("cyc_d_ack",   32'(d_ack),   32'(m_dack));
      check("cyc_i_rdata", i_rdata,      m_irdata);
      check("cyc_d_rdata", d_rdata,      m_drdata);
      check("cyc_ack_excl", 32'(i_ack & d_ack), 32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit on_data, input int start, input string name, output int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (on_data ? d_ack : i_ack) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no ack within 40 cycles", name);
      lat = -1;
    end else begin
      lat = cyc - start;
    end
  endtask

  task automatic d_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input string name, output int lat);
    int start;
    step();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    start = cyc;
    wait_ack(1'b1, start, name, lat);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] addr, input string name, output int lat);
    int start;
    step();
    i_req = 1'b1; i_addr = addr;
    start = cyc;
    wait_ack(1'b0, start, name, lat);
    i_req = 1'b0;
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Directed scenarios.
  initial begin
    int    lat;
    int    t0;
    int    t_d;
    int    t_i;
    int    n_iack;
    string order;

    step();
    chk_en = 1'b1;
    check("rst_busy",    32'(busy),  32'h0);
    check("rst_i_ack",   32'(i_ack), 32'h0);
    check("rst_d_ack",   32'(d_ack), 32'h0);
    check("rst_i_rdata", i_rdata,    32'h0);
    check("rst_d_rdata", d_rdata,    32'h0);
    step();
    reset = 1'b0;

    // Write DEADBEEF, then fetch it through the instruction port.
    d_access(1'b1, 32'h40, 32'hDEADBEEF, "wr40", lat);
    check("wr40_latency", 32'(lat), 32'(LAT + 1));
    check("wr40_busy_at_ack", 32'(busy), 32'h1);
    check("wr40_d_rdata_kept", d_rdata, 32'h0);
    step();
    check("wr40_idle_after", 32'(busy), 32'h0);

    i_access(32'h40, "ird40", lat);
    check("ird40_latency", 32'(lat), 32'(LAT + 1));
    check("ird40_i_rdata", i_rdata, 32'hDEADBEEF);
    check("ird40_d_rdata_kept", d_rdata, 32'h0);

    // Reset, then both ports request on the first edge after release.
    step();
    reset = 1'b1;
    step();
    step();
    check("rst2_i_rdata", i_rdata, 32'h0);
    reset = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h40;
    t0 = cyc; t_d = -1; t_i = -1;
    for (int k = 0; k < 40 && (t_d < 0 || t_i < 0); k++) begin
      step();
      if (d_ack && t_d < 0) begin t_d = cyc - t0; d_req = 1'b0; end
      if (i_ack && t_i < 0) begin t_i = cyc - t0; i_req = 1'b0; end
    end
    check("both_d_ack_at", 32'(t_d), 32'd3);
    check("both_i_ack_at", 32'(t_i), 32'd7);
    step();
    check("both_idle_at_8", 32'(busy), 32'h0);
    check("both_d_rdata", d_rdata, 32'hDEADBEEF);
    check("both_i_rdata", i_rdata, 32'hDEADBEEF);

    // Continuous requests on both ports alternate grants.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h40;
    order = "";
    for (int k = 0; k < 80 && order.len() < 4; k++) begin
      step();
      if (d_ack) order = {order, "D"};
      if (i_ack) order = {order, "I"};
    end
    d_req = 1'b0; i_req = 1'b0;
    n_checks++;
    if (order != "DIDI") begin
      n_errors++;
      $display("FAIL rr_order: got %s expected DIDI", order);
    end

    // Address aliasing.
    d_access(1'b1, 32'h44, 32'h11111111, "wr44", lat);
    d_access(1'b0, 32'h47, 32'h0, "rd47", lat);
    check("rd47_latency", 32'(lat), 32'(LAT + 1));
    check("rd47_d_rdata", d_rdata, 32'h11111111);
    i_access(32'h1044, "ird1044", lat);
    check("ird1044_i_rdata", i_rdata, 32'h11111111);

    // Reset one cycle after a write is accepted aborts it.
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h22222222;
    step();
    check("abort_accepted_busy", 32'(busy), 32'h1);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_d_ack", 32'(d_ack), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_d_rdata", d_rdata, 32'h0);
      check("abort_i_rdata", i_rdata, 32'h0);
    end
    reset = 1'b0;
    d_access(1'b0, 32'h44, 32'h0, "rd44_after_abort", lat);
    check("rd44_after_abort", d_rdata, 32'h11111111);

    // Request dropped after acceptance still completes.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    t0 = cyc;
    step();
    d_req = 1'b0;
    wait_ack(1'b1, t0, "early_drop", lat);
    check("early_drop_latency", 32'(lat), 32'(LAT + 1));
    check("early_drop_d_rdata", d_rdata, 32'hDEADBEEF);

    // A request pulsed while busy is not queued.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    t0 = cyc;
    step();
    i_req = 1'b1; i_addr = 32'h40;
    step();
    i_req = 1'b0;
    wait_ack(1'b1, t0, "busy_ignore", lat);
    d_req = 1'b0;
    check("busy_ignore_latency", 32'(lat), 32'(LAT + 1));
    n_iack = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (i_ack) n_iack++;
    end
    check("busy_ignore_no_i_ack", 32'(n_iack), 32'h0);
    check("busy_ignore_i_rdata", i_rdata, 32'h0);
    check("busy_ignore_d_rdata", d_rdata, 32'h11111111);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
